buffer_controller: RTL and testbench

BUFFER_CONTROLLER -- requirements
Module: buffer_controller

---
 rtl/usb_pkg.sv | 52 +++++
 rtl/timeout_counter.sv | 42 ++++
 rtl/buffer_controller.sv | 184 ++++++++++++++++++
 tb/tb_buffer_controller.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_pkg.sv
// Shared USB encodings: RX PIDs, TX commands and controller FSM states.
package usb_pkg;

    typedef enum logic [2:0] {
        RX_NONE  = 3'd0,
        RX_OUT   = 3'd1,
        RX_IN    = 3'd2,
        RX_DATA0 = 3'd3,
        RX_DATA1 = 3'd4,
        RX_ACK   = 3'd5,
        RX_NAK   = 3'd6,
        RX_STALL = 3'd7
    } rx_pid_e;

    typedef enum logic [2:0] {
        TX_NONE  = 3'd0,
        TX_DATA0 = 3'd1,
        TX_ACK   = 3'd2,
        TX_NAK   = 3'd3,
        TX_STALL = 3'd4
    } tx_pid_e;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_DATA = 3'd1,
        ST_SEND_ACK  = 3'd2,
        ST_SEND_NAK  = 3'd3,
        ST_SEND_DATA = 3'd4,
        ST_WAIT_TX   = 3'd5,
        ST_WAIT_HS   = 3'd6
    } state_e;

    localparam int unsigned TIMER_W = 8;

    // True for the two data-phase PIDs.
    function automatic logic is_data_pid(input rx_pid_e pid);
        return (pid == RX_DATA0) || (pid == RX_DATA1);
    endfunction

    // Handshake/data command owned by each state; only the SEND_* states drive one.
    function automatic tx_pid_e tx_cmd_for_state(input state_e s);
        tx_pid_e cmd;
        case (s)
            ST_SEND_ACK:  cmd = TX_ACK;
            ST_SEND_NAK:  cmd = TX_NAK;
            ST_SEND_DATA: cmd = TX_DATA0;
            default:      cmd = TX_NONE;
        endcase
        return cmd;
    endfunction

endpackage

// File: rtl/timeout_counter.sv
// Saturating wait-cycle counter; rollover_o flags that LIMIT has been reached.
module timeout_counter
    import usb_pkg::*;
#(
    parameter logic [TIMER_W-1:0] LIMIT = 8'd255
) (
    input  logic clk,
    input  logic n_rst,
    input  logic en_i,
    input  logic clr_i,
    output logic rollover_o
);

    logic [TIMER_W-1:0] count_q;
    logic [TIMER_W-1:0] count_d;
    logic               rollover_s;

    assign rollover_s = (count_q == LIMIT);
    assign rollover_o = rollover_s;

    // Next count: clear wins, otherwise count up while enabled and not yet at the limit.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i && !rollover_s) begin
            count_d = count_q + 8'd1;
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/buffer_controller.sv
// USB endpoint buffer controller: sequences OUT/IN transactions, handshakes and buffer ownership.
module buffer_controller
    import usb_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic [2:0] rx_packet,
    input  logic       rx_data_ready,
    input  logic       rx_error,
    input  logic       tx_transfer_active,
    input  logic [6:0] buffer_occupancy,
    input  logic       tx_request,
    output logic [2:0] tx_packet,
    output logic       buffer_reserved,
    output logic       clear,
    output logic       rx_done,
    output logic       tx_done,
    output logic       error
);

    state_e  state_q, state_d;
    logic    seen_q, seen_d;
    logic    from_data_q, from_data_d;
    tx_pid_e tx_packet_q, tx_packet_d;
    logic    reserved_q, reserved_d;
    logic    clear_q, clear_d;
    logic    rx_done_q, rx_done_d;
    logic    tx_done_q, tx_done_d;
    logic    error_q, error_d;
    logic    err_set_s;
    logic    tmo_s;
    logic    tmr_en_s;
    logic    tmr_clr_s;
    rx_pid_e pid_s;

    assign pid_s     = rx_pid_e'(rx_packet);
    assign tmr_en_s  = (state_q == ST_WAIT_DATA) || (state_q == ST_WAIT_HS);
    assign tmr_clr_s = (state_d != state_q);

    timeout_counter #(
        .LIMIT (8'(TIMEOUT))
    ) u_timer (
        .clk        (clk),
        .n_rst      (n_rst),
        .en_i       (tmr_en_s),
        .clr_i      (tmr_clr_s),
        .rollover_o (tmo_s)
    );

    // Next-state, pulse and sticky-error logic for the transaction FSM.
    always_comb begin
        state_d     = state_q;
        seen_d      = seen_q;
        from_data_d = from_data_q;
        clear_d     = 1'b0;
        rx_done_d   = 1'b0;
        tx_done_d   = 1'b0;
        err_set_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rx_data_ready) begin
                    if ((pid_s == RX_OUT) && !rx_error) begin
                        state_d = ST_WAIT_DATA;
                    end else if (pid_s == RX_IN) begin
                        if (tx_request && (buffer_occupancy != 7'd0)) begin
                            state_d = ST_SEND_DATA;
                        end else begin
                            state_d = ST_SEND_NAK;
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT_DATA: begin
                if (rx_data_ready) begin
                    if (is_data_pid(pid_s) && !rx_error) begin
                        state_d   = ST_SEND_ACK;
                        rx_done_d = 1'b1;
                    end else begin
                        // Corrupt or unexpected data phase: drop whatever was written.
                        state_d   = ST_IDLE;
                        clear_d   = 1'b1;
                        err_set_s = 1'b1;
                    end
                end else if (tmo_s) begin
                    state_d   = ST_IDLE;
                    clear_d   = 1'b1;
                    err_set_s = 1'b1;
                end else begin
                    state_d = ST_WAIT_DATA;
                end
            end
            ST_SEND_ACK, ST_SEND_NAK: begin
                state_d     = ST_WAIT_TX;
                seen_d      = 1'b0;
                from_data_d = 1'b0;
            end
            ST_SEND_DATA: begin
                state_d     = ST_WAIT_TX;
                seen_d      = 1'b0;
                from_data_d = 1'b1;
            end
            ST_WAIT_TX: begin
                // Leave only on the falling edge of a transfer that was actually observed.
                if (tx_transfer_active) begin
                    seen_d = 1'b1;
                end else if (seen_q) begin
                    state_d = from_data_q ? ST_WAIT_HS : ST_IDLE;
                end else begin
                    state_d = ST_WAIT_TX;
                end
            end
            ST_WAIT_HS: begin
                if (rx_data_ready) begin
                    state_d = ST_IDLE;
                    if ((pid_s == RX_ACK) && !rx_error) begin
                        tx_done_d = 1'b1;
                        clear_d   = 1'b1;
                    end else begin
                        // Host did not confirm: keep the payload for a retry.
                        err_set_s = 1'b1;
                    end
                end else if (tmo_s) begin
                    state_d   = ST_IDLE;
                    err_set_s = 1'b1;
                end else begin
                    state_d = ST_WAIT_HS;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (err_set_s) begin
            error_d = 1'b1;
        end else if (rx_done_d || tx_done_d) begin
            error_d = 1'b0;
        end else begin
            error_d = error_q;
        end

        tx_packet_d = tx_cmd_for_state(state_d);
        reserved_d  = (state_d != ST_IDLE);
    end

    // State and registered output flops.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= ST_IDLE;
            seen_q      <= 1'b0;
            from_data_q <= 1'b0;
            tx_packet_q <= TX_NONE;
            reserved_q  <= 1'b0;
            clear_q     <= 1'b0;
            rx_done_q   <= 1'b0;
            tx_done_q   <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            seen_q      <= seen_d;
            from_data_q <= from_data_d;
            tx_packet_q <= tx_packet_d;
            reserved_q  <= reserved_d;
            clear_q     <= clear_d;
            rx_done_q   <= rx_done_d;
            tx_done_q   <= tx_done_d;
            error_q     <= error_d;
        end
    end

    assign tx_packet       = tx_packet_q;
    assign buffer_reserved = reserved_q;
    assign clear           = clear_q;
    assign rx_done         = rx_done_q;
    assign tx_done         = tx_done_q;
    assign error           = error_q;

endmodule

// File: tb/tb_buffer_controller.sv
// Self-checking bench for buffer_controller: directed scenarios plus randomized transactions
// scored against a per-transaction outcome model.
module tb_buffer_controller;

    logic       clk;
    logic       n_rst;
    logic [2:0] rx_packet;
    logic       rx_data_ready;
    logic       rx_error;
    logic       tx_transfer_active;
    logic [6:0] buffer_occupancy;
    logic       tx_request;
    logic [2:0] tx_packet;
    logic       buffer_reserved;
    logic       clear;
    logic       rx_done;
    logic       tx_done;
    logic       error;

    int n_cmp = 0;
    int n_fail = 0;
    int n_rx = 0, n_tx = 0, n_clr = 0, n_ack = 0, n_nak = 0, n_dat = 0, n_ovl = 0;
    logic err_model = 1'b0;

    buffer_controller #(.TIMEOUT(255)) dut (
        .clk                (clk),
        .n_rst              (n_rst),
        .rx_packet          (rx_packet),
        .rx_data_ready      (rx_data_ready),
        .rx_error           (rx_error),
        .tx_transfer_active (tx_transfer_active),
        .buffer_occupancy   (buffer_occupancy),
        .tx_request         (tx_request),
        .tx_packet          (tx_packet),
        .buffer_reserved    (buffer_reserved),
        .clear              (clear),
        .rx_done            (rx_done),
        .tx_done            (tx_done),
        .error              (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Event monitor sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (rx_done) n_rx <= n_rx + 1;
        if (tx_done) n_tx <= n_tx + 1;
        if (clear) n_clr <= n_clr + 1;
        if (tx_packet == 3'd2) n_ack <= n_ack + 1;
        if (tx_packet == 3'd3) n_nak <= n_nak + 1;
        if (tx_packet == 3'd1) n_dat <= n_dat + 1;
        if (rx_done && tx_done) n_ovl <= n_ovl + 1;
    end

    task automatic pulse_rx(input logic [2:0] pid, input logic err);
        @(posedge clk); #1;
        rx_data_ready = 1'b1; rx_packet = pid; rx_error = err;
        @(posedge clk); #1;
        rx_data_ready = 1'b0; rx_packet = 3'd0; rx_error = 1'b0;
    endtask

    task automatic do_tx(input int len, input logic stray);
        @(posedge clk); #1;
        tx_transfer_active = 1'b1;
        if (stray) pulse_rx(3'd1, 1'b0);
        repeat (len) @(posedge clk);
        #1;
        tx_transfer_active = 1'b0;
    endtask

    task automatic test_reset();
        n_rst = 1'b1;
        #1 n_rst = 1'b0;
        #5;
        n_cmp++;
        if ({tx_packet, buffer_reserved, clear, rx_done, tx_done, error} !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_outputs got=%b exp=00000000", {tx_packet, buffer_reserved, clear, rx_done, tx_done, error});
        end
        repeat (2) @(posedge clk);
        #1 n_rst = 1'b1;
        err_model = 1'b0;
    endtask

    // One OUT (kind 0) or IN (kind 1) transaction; expectations come from the protocol rules.
    task automatic test_transaction(input string tag, input int kind, input int gap, input logic [2:0] pid,
                                    input logic perr, input logic treq, input logic [6:0] occ, input int txlen);
        int b_rx, b_tx, b_clr, b_ack, b_nak, b_dat, b_ovl;
        int e_rx, e_tx, e_clr, e_ack, e_nak, e_dat;
        logic good, data_path, e_err;
        b_rx = n_rx; b_tx = n_tx; b_clr = n_clr; b_ack = n_ack; b_nak = n_nak; b_dat = n_dat; b_ovl = n_ovl;
        e_rx = 0; e_tx = 0; e_clr = 0; e_ack = 0; e_nak = 0; e_dat = 0;
        e_err = err_model; good = 1'b0; data_path = 1'b0;
        if (kind == 0) begin
            good = !perr && (pid == 3'd3 || pid == 3'd4);
            e_rx = good ? 1 : 0; e_ack = e_rx; e_clr = good ? 0 : 1; e_err = !good;
        end else begin
            data_path = treq && (occ != 7'd0);
            if (data_path) begin
                good = (pid == 3'd5) && !perr;
                e_dat = 1; e_tx = good ? 1 : 0; e_clr = e_tx; e_err = !good;
            end else begin
                e_nak = 1;
            end
        end
        err_model = e_err;

        buffer_occupancy = occ;
        tx_request = treq;
        if (kind == 0) begin
            pulse_rx(3'd1, 1'b0);
            n_cmp++;
            if (buffer_reserved !== 1'b1) begin n_fail++; $display("FAIL %s res_after_out got=%b exp=1", tag, buffer_reserved); end
            repeat (gap) @(posedge clk);
            #1;
            n_cmp++;
            if (buffer_reserved !== 1'b1) begin n_fail++; $display("FAIL %s res_wait_data got=%b exp=1", tag, buffer_reserved); end
            pulse_rx(pid, perr);
            if (good) do_tx(txlen, 1'b0);
        end else begin
            pulse_rx(3'd2, 1'b0);
            tx_request = 1'b0;
            do_tx(txlen, 1'b0);
            n_cmp++;
            if (buffer_reserved !== 1'b1) begin n_fail++; $display("FAIL %s res_during_tx got=%b exp=1", tag, buffer_reserved); end
            if (data_path) pulse_rx(pid, perr);
        end
        repeat (3) @(posedge clk);
        #1;

        n_cmp++; if (n_rx - b_rx !== e_rx) begin n_fail++; $display("FAIL %s rx_done got=%0d exp=%0d", tag, n_rx - b_rx, e_rx); end
        n_cmp++; if (n_tx - b_tx !== e_tx) begin n_fail++; $display("FAIL %s tx_done got=%0d exp=%0d", tag, n_tx - b_tx, e_tx); end
        n_cmp++; if (n_clr - b_clr !== e_clr) begin n_fail++; $display("FAIL %s clear got=%0d exp=%0d", tag, n_clr - b_clr, e_clr); end
        n_cmp++; if (n_ack - b_ack !== e_ack) begin n_fail++; $display("FAIL %s ack_cycles got=%0d exp=%0d", tag, n_ack - b_ack, e_ack); end
        n_cmp++; if (n_nak - b_nak !== e_nak) begin n_fail++; $display("FAIL %s nak_cycles got=%0d exp=%0d", tag, n_nak - b_nak, e_nak); end
        n_cmp++; if (n_dat - b_dat !== e_dat) begin n_fail++; $display("FAIL %s data0_cycles got=%0d exp=%0d", tag, n_dat - b_dat, e_dat); end
        n_cmp++; if (n_ovl - b_ovl !== 0) begin n_fail++; $display("FAIL %s done_overlap got=%0d exp=0", tag, n_ovl - b_ovl); end
        n_cmp++; if (error !== e_err) begin n_fail++; $display("FAIL %s error got=%b exp=%b", tag, error, e_err); end
        n_cmp++; if (buffer_reserved !== 1'b0) begin n_fail++; $display("FAIL %s res_end got=%b exp=0", tag, buffer_reserved); end
        n_cmp++; if (tx_packet !== 3'd0) begin n_fail++; $display("FAIL %s tx_packet_end got=%0d exp=0", tag, tx_packet); end
    endtask

    task automatic test_out_timeout();
        int b_clr;
        b_clr = n_clr;
        pulse_rx(3'd1, 1'b0);
        repeat (240) @(posedge clk);
        #1;
        n_cmp++; if (buffer_reserved !== 1'b1) begin n_fail++; $display("FAIL out_tmo_early_res got=%b exp=1", buffer_reserved); end
        n_cmp++; if (error !== err_model) begin n_fail++; $display("FAIL out_tmo_early_err got=%b exp=%b", error, err_model); end
        repeat (25) @(posedge clk);
        #1;
        err_model = 1'b1;
        n_cmp++; if (buffer_reserved !== 1'b0) begin n_fail++; $display("FAIL out_tmo_res got=%b exp=0", buffer_reserved); end
        n_cmp++; if (error !== 1'b1) begin n_fail++; $display("FAIL out_tmo_err got=%b exp=1", error); end
        n_cmp++; if (n_clr - b_clr !== 1) begin n_fail++; $display("FAIL out_tmo_clear got=%0d exp=1", n_clr - b_clr); end
    endtask

    task automatic test_hs_timeout();
        int b_clr, b_tx;
        buffer_occupancy = 7'd8;
        tx_request = 1'b1;
        pulse_rx(3'd2, 1'b0);
        tx_request = 1'b0;
        do_tx(3, 1'b0);
        b_clr = n_clr; b_tx = n_tx;
        repeat (250) @(posedge clk);
        #1;
        n_cmp++; if (buffer_reserved !== 1'b1) begin n_fail++; $display("FAIL hs_tmo_early_res got=%b exp=1", buffer_reserved); end
        repeat (20) @(posedge clk);
        #1;
        err_model = 1'b1;
        n_cmp++; if (buffer_reserved !== 1'b0) begin n_fail++; $display("FAIL hs_tmo_res got=%b exp=0", buffer_reserved); end
        n_cmp++; if (error !== 1'b1) begin n_fail++; $display("FAIL hs_tmo_err got=%b exp=1", error); end
        n_cmp++; if (n_clr - b_clr !== 0 || n_tx - b_tx !== 0) begin n_fail++; $display("FAIL hs_tmo_pulses clear=%0d tx_done=%0d exp=0/0", n_clr - b_clr, n_tx - b_tx); end
    endtask

    task automatic test_reset_mid();
        int b_clr;
        buffer_occupancy = 7'd8;
        tx_request = 1'b1;
        pulse_rx(3'd2, 1'b0);
        tx_request = 1'b0;
        do_tx(4, 1'b0);
        b_clr = n_clr;
        #3 n_rst = 1'b0;
        #1;
        n_cmp++;
        if ({tx_packet, buffer_reserved, clear, rx_done, tx_done, error} !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_mid_outputs got=%b exp=00000000", {tx_packet, buffer_reserved, clear, rx_done, tx_done, error});
        end
        repeat (3) @(posedge clk);
        #1 n_rst = 1'b1;
        err_model = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (n_clr - b_clr !== 0) begin n_fail++; $display("FAIL reset_mid_clear got=%0d exp=0", n_clr - b_clr); end
        n_cmp++; if (buffer_reserved !== 1'b0) begin n_fail++; $display("FAIL reset_mid_res got=%b exp=0", buffer_reserved); end
    endtask

    task automatic test_wait_tx_ignore();
        int b_rx, b_nak;
        b_rx = n_rx; b_nak = n_nak;
        buffer_occupancy = 7'd0;
        tx_request = 1'b1;
        pulse_rx(3'd2, 1'b0);
        do_tx(5, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (n_nak - b_nak !== 1) begin n_fail++; $display("FAIL ignore_nak got=%0d exp=1", n_nak - b_nak); end
        n_cmp++; if (n_rx - b_rx !== 0) begin n_fail++; $display("FAIL ignore_rx_done got=%0d exp=0", n_rx - b_rx); end
        n_cmp++; if (buffer_reserved !== 1'b0) begin n_fail++; $display("FAIL ignore_res got=%b exp=0", buffer_reserved); end
    endtask

    task automatic test_random(input int iters);
        int kind, sel, gap, txlen;
        logic [2:0] pid;
        logic perr, treq;
        logic [6:0] occ;
        for (int i = 0; i < iters; i++) begin
            kind = int'($urandom_range(0, 1));
            sel = int'($urandom_range(0, 3));
            gap = int'($urandom_range(1, 60));
            txlen = int'($urandom_range(1, 12));
            perr = 1'b0; treq = 1'b1; occ = 7'd1;
            if (kind == 0) begin
                case (sel)
                    0: pid = 3'd3;
                    1: pid = 3'd4;
                    2: begin pid = ($urandom_range(0, 1) == 0) ? 3'd3 : 3'd4; perr = 1'b1; end
                    default: begin
                        pid = 3'($urandom_range(0, 7));
                        if (pid == 3'd3 || pid == 3'd4) pid = 3'd5;
                    end
                endcase
            end else begin
                treq = 1'($urandom_range(0, 3) != 0);
                occ = ($urandom_range(0, 3) == 0) ? 7'd0 : 7'($urandom_range(1, 64));
                case (sel)
                    0, 1: pid = 3'd5;
                    2: begin pid = 3'd5; perr = 1'b1; end
                    default: pid = ($urandom_range(0, 1) == 0) ? 3'd6 : 3'd7;
                endcase
            end
            test_transaction("random", kind, gap, pid, perr, treq, occ, txlen);
        end
    endtask

    initial begin
        rx_packet = 3'd0; rx_data_ready = 1'b0; rx_error = 1'b0;
        tx_transfer_active = 1'b0; buffer_occupancy = 7'd0; tx_request = 1'b0;
        test_reset();
        test_transaction("out_data0", 0, 20, 3'd3, 1'b0, 1'b0, 7'd0, 6);
        test_transaction("in_data_ack", 1, 0, 3'd5, 1'b0, 1'b1, 7'd8, 8);
        test_transaction("in_empty_nak", 1, 0, 3'd0, 1'b0, 1'b1, 7'd0, 4);
        test_out_timeout();
        test_transaction("out_after_tmo", 0, 20, 3'd4, 1'b0, 1'b0, 7'd0, 5);
        test_transaction("out_data1_err", 0, 10, 3'd4, 1'b1, 1'b0, 7'd0, 3);
        test_transaction("in_host_nak", 1, 0, 3'd6, 1'b0, 1'b1, 7'd64, 3);
        test_hs_timeout();
        test_reset_mid();
        test_wait_tx_ignore();
        test_random(40);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
